tribus_rr_sched: RTL

Round-robin scheduler that shares one tri-state classifier output bus among `N` requesting channels. It grants one channel at a time and drives the classifier enable and 4-bit sample. It then reports the classification: 0 for values 0–4, 1 for 5–9, out-of-range for 10–15. It sits between the per-channel sample sources and the shared tri-state classifier stage, and it ensures only one channel ever owns the bus.

---
 rtl/tribus_rr_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tribus_rr_sched.sv
// tribus_rr_sched: round-robin owner of a shared tri-state classifier bus.
// Grants one of N channels, holds the bus for 1+HOLD cycles, then reports
// the 4-bit sample class (0: 0..4, 1: 5..9, out-of-range: 10..15).
// Optional feature macro: TRIBUS_PRIO_EN (channel 0 gets fixed top priority).
module tribus_rr_sched #(
    parameter int unsigned N    = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [4*N-1:0]  val,
    output logic [N-1:0]    grant,
    output logic            en_out,
    output logic [3:0]      sel_val,
    output logic            class_bit,
    output logic            class_oor,
    output logic            class_vld,
    output logic            busy,
    output logic [7:0]      err_cnt
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = 4;
    localparam int unsigned HW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   win, win_d;
    logic [HW-1:0]   cnt, cnt_d;
    logic [N-1:0]    grant_d;
    logic            en_d;
    logic [CW-1:0]   sel_d;
    logic            bit_d;
    logic            oor_d;
    logic            vld_d;
    logic            busy_d;
    logic [7:0]      err_d;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   ptr_adv;
    logic            is_oor;
    logic            is_one;

    // Winner search: first requester at or after ptr, wrapping modulo N
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
`ifdef TRIBUS_PRIO_EN
        if (req[0]) begin
            pick = '0;
        end
`endif
    end

    // Pointer value after the current transaction ends (release or abort)
    always_comb begin
        ptr_adv = (win == PW'(N - 1)) ? '0 : win + PW'(1);
`ifdef TRIBUS_PRIO_EN
        if (win == '0) begin
            ptr_adv = ptr;
        end
`endif
    end

    // Classification of the latched sample
    always_comb begin
        is_oor = (sel_val >= 4'd10);
        is_one = (sel_val >= 4'd5) && (sel_val <= 4'd9);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        win_d   = win;
        cnt_d   = cnt;
        grant_d = grant;
        en_d    = en_out;
        sel_d   = sel_val;
        bit_d   = class_bit;
        oor_d   = class_oor;
        vld_d   = 1'b0;
        err_d   = err_cnt;

        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_d       = S_GRANT;
                    win_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    en_d          = 1'b1;
                    for (int unsigned i = 0; i < N; i++) begin
                        if (PW'(i) == pick) begin
                            sel_d = val[CW*i +: CW];
                        end
                    end
                end
            end
            S_GRANT: begin
                if (!req[win]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    en_d    = 1'b0;
                    ptr_d   = ptr_adv;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = HW'(HOLD - 1);
                end
            end
            S_HOLD: begin
                if (!req[win]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    en_d    = 1'b0;
                    ptr_d   = ptr_adv;
                end else if (cnt == '0) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    en_d    = 1'b0;
                    vld_d   = 1'b1;
                    bit_d   = is_one;
                    oor_d   = is_oor;
                    ptr_d   = ptr_adv;
                    if (is_oor && (err_cnt != 8'hFF)) begin
                        err_d = err_cnt + 8'd1;
                    end
                end else begin
                    cnt_d = cnt - HW'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            grant     <= '0;
            en_out    <= 1'b0;
            sel_val   <= '0;
            class_bit <= 1'b0;
            class_oor <= 1'b0;
            class_vld <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            win       <= win_d;
            cnt       <= cnt_d;
            grant     <= grant_d;
            en_out    <= en_d;
            sel_val   <= sel_d;
            class_bit <= bit_d;
            class_oor <= oor_d;
            class_vld <= vld_d;
            busy      <= busy_d;
            err_cnt   <= err_d;
        end
    end

endmodule
